// File: rtl/cache_pkg.sv
// Shared cache constants, refill FSM state type and address field helpers
// used by both the cache top and the refill controller.
package cache_pkg;

   localparam int ADDR_W     = 16;
   localparam int DATA_W     = 16;
   localparam int OFFSET_W   = 2;
   localparam int INDEX_W    = 4;
   localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W;
   localparam int LINE_WORDS = 2 ** OFFSET_W;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      FLUSH,
      COMMIT
   } refill_state_t;

   function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
      return addr[ADDR_W-1 -: TAG_W];
   endfunction

   function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
      return addr[OFFSET_W +: INDEX_W];
   endfunction

   function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] addr);
      return addr[OFFSET_W-1:0];
   endfunction

endpackage

// File: rtl/refill_word_ctr.sv
// Word slot counter for a line refill: starts at the critical word, wraps
// around the line, and counts accepted words so the FSM knows when the line is full.
module refill_word_ctr
   import cache_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic [OFFSET_W-1:0] offset,
   input  logic                inc,
   output logic [OFFSET_W-1:0] word,
   output logic                first,
   output logic                last
);

   logic [OFFSET_W-1:0] count;

   // The slot wraps naturally at the line boundary since it is exactly OFFSET_W bits wide.
   always_ff @(posedge clk) begin
      if (!rst) begin
         word  <= '0;
         count <= '0;
      end else if (load) begin
         word  <= offset;
         count <= '0;
      end else if (inc) begin
         word  <= word + 1'b1;
         count <= count + 1'b1;
      end
   end

   assign first = (count == '0);
   assign last  = (count == OFFSET_W'(LINE_WORDS - 1));

endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss refill engine: fetches a line critical-word-first, writes it into the
// victim way through a registered fill stage, then commits tag and valid.
module cache_refill_ctrl
   import cache_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                miss_valid,
   input  logic [ADDR_W-1:0]   miss_addr,
   input  logic                miss_way,
   output logic                miss_ready,
   output logic                mem_req,
   output logic [ADDR_W-1:0]   mem_addr,
   input  logic                mem_ack,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                fill_we,
   output logic                fill_way,
   output logic [INDEX_W-1:0]  fill_index,
   output logic [OFFSET_W-1:0] fill_word,
   output logic [DATA_W-1:0]   fill_data,
   output logic                crit_valid,
   output logic                tag_we,
   output logic [TAG_W-1:0]    tag_value,
   output logic                done
);

   refill_state_t state, next_state;

   logic [TAG_W-1:0]    tag_q;
   logic [INDEX_W-1:0]  index_q;
   logic                way_q;
   logic [OFFSET_W-1:0] ctr_word;
   logic                ctr_first;
   logic                ctr_last;
   logic                accept;
   logic                take;

   assign accept = (state == IDLE) && miss_valid;
   assign take   = (state == FETCH) && mem_ack;

   refill_word_ctr u_word_ctr (
      .clk    (clk),
      .rst    (rst),
      .load   (accept),
      .offset (addr_offset(miss_addr)),
      .inc    (take),
      .word   (ctr_word),
      .first  (ctr_first),
      .last   (ctr_last)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      miss_ready = 1'b0;
      mem_req    = 1'b0;
      mem_addr   = '0;
      tag_we     = 1'b0;
      tag_value  = '0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            miss_ready = 1'b1;
            if (miss_valid) begin
               next_state = FETCH;
            end
         end
         FETCH: begin
            mem_req  = 1'b1;
            mem_addr = {tag_q, index_q, ctr_word};
            if (mem_ack && ctr_last) begin
               next_state = FLUSH;
            end
         end
         FLUSH: begin
            next_state = COMMIT;
         end
         COMMIT: begin
            tag_we     = 1'b1;
            tag_value  = tag_q;
            done       = 1'b1;
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Way and line are frozen at accept so the fill target cannot drift mid-refill.
   always_ff @(posedge clk) begin
      if (!rst) begin
         tag_q   <= '0;
         index_q <= '0;
         way_q   <= 1'b0;
      end else if (accept) begin
         tag_q   <= addr_tag(miss_addr);
         index_q <= addr_index(miss_addr);
         way_q   <= miss_way;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         fill_we    <= 1'b0;
         crit_valid <= 1'b0;
         fill_word  <= '0;
         fill_data  <= '0;
      end else begin
         fill_we    <= take;
         crit_valid <= take && ctr_first;
         if (take) begin
            fill_word <= ctr_word;
            fill_data <= mem_rdata;
         end
      end
   end

   assign fill_way   = way_q;
   assign fill_index = index_q;

endmodule
